// File: rtl/gate_test_sequencer.sv
// Self-checking sweep sequencer for a 2-input gate: drives 00,01,10,11, waits a
// settle time per vector, samples the gate output and tallies mismatches.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          EXPECT_OP     = 1'b0,
  parameter int unsigned ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_r,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int unsigned      CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       vec;
  logic             exp_c;
  logic             mismatch_c;
  logic [ERR_W-1:0] err_nxt_c;

  // Gate inputs come straight from the vector register
  assign dut_a = vec[1];
  assign dut_b = vec[0];

  // Expected response for the vector currently driven, and the saturating tally
  always_comb begin
    exp_c      = EXPECT_OP ? (vec[1] & vec[0]) : ~(vec[1] & vec[0]);
    mismatch_c = (dut_r != exp_c);
    err_nxt_c  = err_count;
    if (mismatch_c && (err_count != ERR_MAX)) begin
      err_nxt_c = err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      vec              <= 2'b00;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= 2'b00;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            vec              <= 2'b00;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 2'b00;
            pass             <= 1'b0;
            cnt              <= CNT_LOAD;
            busy             <= 1'b1;
            state            <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CHECK: begin
          err_count <= err_nxt_c;
          if (mismatch_c && !first_fail_valid) begin
            first_fail_vec   <= vec;
            first_fail_valid <= 1'b1;
          end
          if (vec == 2'b11) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt_c == '0);
            state <= DONE;
          end else begin
            vec   <= vec + 2'd1;
            cnt   <= CNT_LOAD;
            state <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: several parameterisations share one
// behavioural gate model selectable per sweep.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic start_d;
  logic [1:0] mode;   // 0 NAND, 1 stuck-1, 2 stuck-0, 3 AND

  always #5 clk = ~clk;

  function automatic logic gate_model(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'd0:    return ~(a & b);
      2'd1:    return 1'b1;
      2'd2:    return 1'b0;
      default: return a & b;
    endcase
  endfunction

  logic a_a, a_b, a_busy, a_done, a_pass, a_ffv;
  logic [2:0] a_err;
  logic [1:0] a_ffvec;
  logic b_a, b_b, b_busy, b_done, b_pass, b_ffv;
  logic [0:0] b_err;
  logic [1:0] b_ffvec;
  logic c_a, c_b, c_busy, c_done, c_pass, c_ffv;
  logic [2:0] c_err;
  logic [1:0] c_ffvec;
  logic d_a, d_b, d_busy, d_done, d_pass, d_ffv;
  logic [2:0] d_err;
  logic [1:0] d_ffvec;

  wire a_r = gate_model(mode, a_a, a_b);
  wire b_r = gate_model(mode, b_a, b_b);
  wire c_r = gate_model(mode, c_a, c_b);
  wire d_r = gate_model(2'd0, d_a, d_b);

  gate_test_sequencer #(.SETTLE_CYCLES(1), .EXPECT_OP(1'b0), .ERR_W(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(a_a), .dut_b(a_b), .dut_r(a_r),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_fail_vec(a_ffvec), .first_fail_valid(a_ffv));

  gate_test_sequencer #(.SETTLE_CYCLES(1), .EXPECT_OP(1'b0), .ERR_W(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(b_a), .dut_b(b_b), .dut_r(b_r),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_fail_vec(b_ffvec), .first_fail_valid(b_ffv));

  gate_test_sequencer #(.SETTLE_CYCLES(1), .EXPECT_OP(1'b1), .ERR_W(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(c_a), .dut_b(c_b), .dut_r(c_r),
    .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err),
    .first_fail_vec(c_ffvec), .first_fail_valid(c_ffv));

  gate_test_sequencer #(.SETTLE_CYCLES(3), .EXPECT_OP(1'b0), .ERR_W(3)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .dut_a(d_a), .dut_b(d_b), .dut_r(d_r),
    .busy(d_busy), .done(d_done), .pass(d_pass), .err_count(d_err),
    .first_fail_vec(d_ffvec), .first_fail_valid(d_ffv));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [2:0] a_err;
    logic [1:0] a_ffvec;
    logic       a_ffv;
    logic       a_pass;
    logic [0:0] b_err;
    logic [2:0] c_err;
    logic       c_pass;
  } vec_t;

  vec_t tbl[4];

  // One sweep on instances a/b/c, checking cycle-by-cycle timing and final results
  task automatic run_sweep(input vec_t v, input string tag);
    logic timing_ok;
    logic       e_busy, e_done;
    logic [1:0] e_vec;
    mode = v.mode;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    timing_ok = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      e_busy = (k <= 8);
      e_done = (k == 9);
      e_vec  = (k <= 8) ? 2'((k - 1) / 2) : 2'b11;
      if (a_busy !== e_busy || a_done !== e_done || {a_a, a_b} !== e_vec ||
          b_done !== e_done || c_done !== e_done || c_busy !== e_busy)
        timing_ok = 1'b0;
      if (k < 9) begin
        @(posedge clk); #1;
      end
    end
    check({tag, " timing"}, 32'(timing_ok), 32'd1);
    check({tag, " a_err"}, 32'(a_err), 32'(v.a_err));
    check({tag, " a_ffvec"}, 32'(a_ffvec), 32'(v.a_ffvec));
    check({tag, " a_ffv"}, 32'(a_ffv), 32'(v.a_ffv));
    check({tag, " a_pass"}, 32'(a_pass), 32'(v.a_pass));
    check({tag, " b_err"}, 32'(b_err), 32'(v.b_err));
    check({tag, " c_err"}, 32'(c_err), 32'(v.c_err));
    check({tag, " c_pass"}, 32'(c_pass), 32'(v.c_pass));
    @(posedge clk); #1;
    check({tag, " hold"}, 32'({a_done, a_busy, a_a, a_b, a_err}), 32'({1'b0, 1'b0, 1'b1, 1'b1, v.a_err}));
  endtask

  int busy_cnt, done_cnt, done_at;
  logic busy_contig;

  initial begin
    //          mode  a_err  a_ffvec a_ffv a_pass b_err c_err c_pass
    tbl[0] = '{2'd0, 3'd0, 2'b00, 1'b0, 1'b1, 1'd0, 3'd4, 1'b0};
    tbl[1] = '{2'd1, 3'd1, 2'b11, 1'b1, 1'b0, 1'd1, 3'd3, 1'b0};
    tbl[2] = '{2'd2, 3'd3, 2'b00, 1'b1, 1'b0, 1'd1, 3'd1, 1'b0};
    tbl[3] = '{2'd3, 3'd4, 2'b00, 1'b1, 1'b0, 1'd1, 3'd0, 1'b1};

    rst_n = 1'b0; start = 1'b0; start_d = 1'b0; mode = 2'd0;
    #1;
    check("reset outs", 32'({a_a, a_b, a_busy, a_done, a_pass, a_ffv}), 32'd0);
    check("reset err/ffvec", 32'({a_err, a_ffvec}), 32'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_sweep(tbl[i], $sformatf("sweep%0d", i));

    // Long settle time with extra start pulses while busy
    busy_cnt = 0; done_cnt = 0; done_at = 0; busy_contig = 1'b1;
    @(negedge clk) start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (d_busy) busy_cnt++;
      if (d_busy !== (k <= 16)) busy_contig = 1'b0;
      if (d_done) begin done_cnt++; done_at = k; end
      start_d = (k == 2 || k == 10);
      @(posedge clk); #1;
    end
    start_d = 1'b0;
    check("long busy count", 32'(busy_cnt), 32'd16);
    check("long busy window", 32'(busy_contig), 32'd1);
    check("long done count", 32'(done_cnt), 32'd1);
    check("long done cycle", 32'(done_at), 32'd17);
    check("long results", 32'({d_pass, d_err, d_ffv}), 32'({1'b1, 3'd0, 1'b0}));

    // Asynchronous reset during CHECK of vector 10
    mode = 2'd2;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre-reset vec", 32'({a_a, a_b}), 32'b10);
    check("pre-reset err", 32'(a_err), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outs", 32'({a_a, a_b, a_busy, a_done, a_pass, a_ffv, a_ffvec, a_err}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (a_done) done_cnt++;
      if (a_busy) busy_cnt++;
    end
    check("no done after abort", 32'(done_cnt), 32'd0);
    check("idle after abort", 32'(busy_cnt), 32'd0);
    run_sweep(tbl[0], "post-reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
